// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: register-access protocol controller behind the SPI byte deserializer.
// Decodes each chip-select frame (cmd byte, then data) into single-cycle register
// bus writes/reads and prefetches read data into tx_byte ahead of the next MISO byte.
// Build option: define SPI_REG_CTRL_AINC_EN to auto-increment the address after every
// access; left undefined, the address stays at the cmd value for the whole frame.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W  = 7,
    parameter logic [7:0]  ID_BYTE = 8'hA5
) (
    input  logic              SPI_CLK,
    input  logic              RST,
    input  logic              start_of_transfer,
    input  logic              end_of_transfer,
    input  logic [7:0]        mosi_data_out,
    input  logic              mosi_data_ready,
    input  logic              miso_data_request,
    output logic [7:0]        miso_data_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [7:0]        tx_q, tx_d;
    // fetch_q: a reg_re was issued last cycle, so reg_rdata is valid now
    logic              fetch_q, fetch_d;
    // rd_adv_q: a MISO byte was consumed last cycle; step addr and fetch the next one
    logic              rd_adv_q, rd_adv_d;
    logic [ADDR_W-1:0] addr_inc;

`ifdef SPI_REG_CTRL_AINC_EN
    assign addr_inc = addr_q + ADDR_W'(1);
`else
    assign addr_inc = addr_q;
`endif

    // Next-state logic: frame decode, strobe generation and read prefetch
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        tx_d     = tx_q;
        fetch_d  = re_q;
        rd_adv_d = 1'b0;

        // An issued read always lands in tx_byte, even after end_of_transfer
        if (fetch_q) begin
            tx_d = reg_rdata;
        end
        // Address steps the cycle after a write strobe
        if (we_q) begin
            addr_d = addr_inc;
        end
        if (rd_adv_q) begin
            addr_d = addr_inc;
            re_d   = 1'b1;
        end

        if (start_of_transfer) begin
            // New frame overrides everything, including a pending prefetch
            state_d  = StCmd;
            tx_d     = ID_BYTE;
            fetch_d  = 1'b0;
            we_d     = 1'b0;
            re_d     = 1'b0;
            rd_adv_d = 1'b0;
        end else if (end_of_transfer) begin
            // Frame closed: drop any byte arriving now and issue no further strobes
            state_d  = StIdle;
            we_d     = 1'b0;
            re_d     = 1'b0;
            rd_adv_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCmd: begin
                    if (mosi_data_ready) begin
                        addr_d  = mosi_data_out[ADDR_W-1:0];
                        state_d = mosi_data_out[7] ? StRd : StWr;
                        re_d    = mosi_data_out[7];
                    end
                end
                StWr: begin
                    if (mosi_data_ready) begin
                        we_d    = 1'b1;
                        wdata_d = mosi_data_out;
                    end
                end
                StRd: begin
                    if (miso_data_request) begin
                        rd_adv_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            tx_q     <= ID_BYTE;
            fetch_q  <= 1'b0;
            rd_adv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            tx_q     <= tx_d;
            fetch_q  <= fetch_d;
            rd_adv_q <= rd_adv_d;
        end
    end

    assign miso_data_in = tx_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_we       = we_q;
    assign reg_re       = re_q;
    assign busy         = (state_q != StIdle);

endmodule
